app_mult_err_monitor: RTL and testbench
=======================================

# app_mult_err_monitor

Result-side error monitor for the approximate signed multipliers under CPD test. It watches the same `en`/`A`/`B` bus that drives an `app_mult_signed<W1>x<W2>` instance and samples that instance's `sum` a fixed latency after each request. It compares `sum` against the exact signed product and accumulates error statistics (sample count, error count, absolute-error sum, max absolute error), so runs and on-board tests report accuracy without post-processing waveforms.

## Interface
- `WIDTH1`, default 8: width of signed operand A.
- `WIDTH2`, default 8: width of signed operand B.
- `LAT`, default 3: cycles from request start to valid `sum`; legal range ≥1.
- `ACC_W`, default 32: width of all statistic counters.

Ports:
- `sys_clk`  in  1: single clock; all logic on rising edge.
- `sys_rst`  in  1: synchronous, active-high reset.
- `en`  in  1: multiplier enable; a request starts on its 0→1 transition.
- `A`  in  WIDTH1: signed operand, same net as multiplier A.
- `B`  in  WIDTH2: signed operand, same net as multiplier B.
- `sum`  in  WIDTH1+WIDTH2: signed approximate product from the multiplier.
- `clr`  in  1: synchronous statistics clear.
- `done`  out  1: one-cycle pulse when a sample has been folded into the statistics.
- `last_err`  out  WIDTH1+WIDTH2+1: signed error of the latest sample, computed as `sum − A*B`.
- `sample_cnt`  out  ACC_W: completed samples.
- `err_cnt`  out  ACC_W: samples with nonzero error.
- `abort_cnt`  out  ACC_W: requests dropped because `en` fell before sampling.
- `abs_err_sum`  out  ACC_W: Σ|err|.
- `max_abs_err`  out  WIDTH1+WIDTH2+1: largest |err| seen.

## Operation
- `en_d` is a registered copy of `en`. A rise is `en & ~en_d`.
- FSM states are IDLE, WAIT, UPDATE.
- IDLE:
  - On a rise, latch `A` and `B`, load the wait counter with LAT, and go to WAIT.
  - Rises seen in WAIT or UPDATE are ignored.
- WAIT:
  - Decrement the counter every edge.
  - If `en`=0 at any edge in WAIT, increment `abort_cnt` and go to IDLE.
  - At the edge where the counter reaches 0 (and `en`=1), capture `sum`, compute `err`, and go to UPDATE.
- UPDATE:
  - One cycle. Update the statistics, set `done`, and go to IDLE.
  - A rise on this edge is not accepted. The next request needs `en` to fall and rise again.
- Arithmetic:
  - Exact product uses full-width signed `A*B` (WIDTH1+WIDTH2 bits; no overflow, including −2^(W1−1)·−2^(W2−1)).
  - `err` is sign-extended to WIDTH1+WIDTH2+1 bits.
  - |err| is unsigned in WIDTH1+WIDTH2+1 bits.
- Statistics:
  - `sample_cnt`+1.
  - `err_cnt`+1 if err≠0.
  - `abs_err_sum` += |err|, zero-extended.
  - `max_abs_err` = max(`max_abs_err`, |err|).
  - All ACC_W counters saturate at all-ones and never wrap.
- Priority: `sys_rst` > `clr` > normal operation.
  - `clr` zeroes all counters, `max_abs_err` and `last_err`, forces IDLE, and suppresses `done`.
  - A request in flight at `clr` is discarded and not counted as aborted.

## Timing
- t0 is the edge where a rise is seen.
- `sum` is sampled at edge t0+LAT.
- Statistics and `last_err` update at edge t0+LAT+1.
- `done` is high for the cycle following t0+LAT+1.
- The earliest next accepted rise is edge t0+LAT+2. It requires `en` low at some edge in between, and at least one edge with `en` low.
- An abort is registered at the first edge in t0+1…t0+LAT with `en`=0. `abort_cnt` is visible the next cycle.
- Reset values: every output is 0, FSM is IDLE, `en_d` is 0. If `en` is high during reset, no rise is seen until it falls and rises again.
- Reset or `clr` mid-WAIT or mid-UPDATE returns to IDLE on that edge with no statistic change.
- Statistic outputs are registered and stable between `done` pulses.

## Test plan
- **Exact result:** WIDTH1=WIDTH2=8, LAT=3. `en` rises with A=12, B=10, and `sum` is driven 120 at t0+3. Required: `done` in the cycle after t0+4, `last_err`=0, `sample_cnt`=1, `err_cnt`=0, `abs_err_sum`=0.
- **Signed errors:**
  - A=5, B=−3, `sum`=−16 → `last_err`=−1, `err_cnt`=1, `abs_err_sum`=1, `max_abs_err`=1.
  - Then A=−128, B=−128, `sum`=16380 → `last_err`=−4, `abs_err_sum`=5, `max_abs_err`=4, `sample_cnt`=2.
- **Abort:** `en` is high for only 2 cycles with LAT=3. Required: `abort_cnt`=1, `sample_cnt` unchanged, no `done`. A following full-length request is then accepted normally.
- **Saturation:** ACC_W=4, 20 back-to-back requests each with |err|=3. Required: `sample_cnt`=15, `err_cnt`=15, `abs_err_sum`=15, with no wrap.
- **clr/reset collision:**
  - `clr` asserted on the UPDATE edge → counters 0, no `done`.
  - `sys_rst` asserted mid-WAIT → all outputs 0, and the next rise is accepted normally.

Source files
------------

// File: rtl/app_mult_err_monitor.sv
// -----------------------------------------------------------------------------
// app_mult_err_monitor
//
// Result-side accuracy monitor for an approximate signed multiplier. It snoops
// the multiplier's en/A/B request bus, waits LAT cycles, samples the
// multiplier's sum and compares it to the exact signed product A*B. Error
// statistics are accumulated in saturating counters.
//
// Ports
//   sys_clk      in   clock, rising edge
//   sys_rst      in   synchronous active-high reset
//   en           in   multiplier enable; a request starts on its 0->1 edge
//   A, B         in   signed operands (same nets as the multiplier's)
//   sum          in   signed approximate product from the multiplier
//   clr          in   synchronous statistics clear
//   done         out  one-cycle pulse after a sample is folded in
//   last_err     out  signed error sum - A*B of the latest sample
//   sample_cnt   out  completed samples
//   err_cnt      out  samples with nonzero error
//   abort_cnt    out  requests dropped because en fell before sampling
//   abs_err_sum  out  sum of |err|
//   max_abs_err  out  largest |err| seen
// -----------------------------------------------------------------------------
module app_mult_err_monitor #(
   parameter int WIDTH1 = 8,
   parameter int WIDTH2 = 8,
   parameter int LAT    = 3,
   parameter int ACC_W  = 32
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic                     en,
   input  logic [WIDTH1-1:0]        A,
   input  logic [WIDTH2-1:0]        B,
   input  logic [WIDTH1+WIDTH2-1:0] sum,
   input  logic                     clr,
   output logic                     done,
   output logic [WIDTH1+WIDTH2:0]   last_err,
   output logic [ACC_W-1:0]         sample_cnt,
   output logic [ACC_W-1:0]         err_cnt,
   output logic [ACC_W-1:0]         abort_cnt,
   output logic [ACC_W-1:0]         abs_err_sum,
   output logic [WIDTH1+WIDTH2:0]   max_abs_err
);

   localparam int PW = WIDTH1 + WIDTH2;           // product width
   localparam int EW = PW + 1;                    // error width
   localparam int CW = $clog2(LAT + 1);           // wait counter width
   localparam int SW = ((ACC_W > EW) ? ACC_W : EW) + 1;  // overflow-safe adder

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_UPDATE} state_t;

   state_t                  state_q, state_d;
   logic                    en_d;
   logic                    en_blk;   // en was high during reset; wait for a fall
   logic [CW-1:0]           cnt_q;
   logic signed [WIDTH1-1:0] a_q;
   logic signed [WIDTH2-1:0] b_q;
   logic signed [EW-1:0]    err_q;

   logic                    rise;
   logic                    abort_evt;
   logic                    capture;
   logic                    upd;
   logic signed [PW-1:0]    prod_c;
   logic signed [EW-1:0]    err_c;
   logic [EW-1:0]           abs_c;
   logic [SW-1:0]           asum_wide;
   logic [ACC_W-1:0]        asum_next;

   assign rise      = en & ~en_d & ~en_blk;
   assign abort_evt = (state_q == S_WAIT) & ~en;
   assign capture   = (state_q == S_WAIT) & en & (cnt_q == CW'(1));
   assign upd       = (state_q == S_UPDATE);

   // Both operands sign-extended to full product width, so even
   // -2^(W1-1) * -2^(W2-1) is exact.
   assign prod_c = $signed({{WIDTH2{a_q[WIDTH1-1]}}, a_q}) *
                   $signed({{WIDTH1{b_q[WIDTH2-1]}}, b_q});
   assign err_c  = $signed({sum[PW-1], sum}) - $signed({prod_c[PW-1], prod_c});
   assign abs_c  = err_q[EW-1] ? (~err_q + EW'(1)) : err_q;

   assign asum_wide = SW'(abs_err_sum) + SW'(abs_c);
   assign asum_next = (asum_wide > SW'({ACC_W{1'b1}})) ? {ACC_W{1'b1}}
                                                      : asum_wide[ACC_W-1:0];

   function automatic logic [ACC_W-1:0] sat_inc(input logic [ACC_W-1:0] v);
      return (&v) ? v : v + ACC_W'(1);
   endfunction

   // NOTE: sequential state is written with <= so every register samples the
   // pre-edge values; blocking assignments here would create order races.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // NOTE: state_d gets its default before the case, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (rise) state_d = S_WAIT;
         S_WAIT: begin
            if (!en)         state_d = S_IDLE;
            else if (capture) state_d = S_UPDATE;
         end
         S_UPDATE: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (clr) state_d = S_IDLE;
   end

   // NOTE: operand and error holding registers carry no reset; they are only
   // read after being loaded by an accepted request.
   always_ff @(posedge sys_clk) begin
      if (state_q == S_IDLE && rise) begin
         a_q <= $signed(A);
         b_q <= $signed(B);
      end
      if (capture) err_q <= err_c;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         en_d        <= 1'b0;
         en_blk      <= en;
         cnt_q       <= '0;
         done        <= 1'b0;
         last_err    <= '0;
         sample_cnt  <= '0;
         err_cnt     <= '0;
         abort_cnt   <= '0;
         abs_err_sum <= '0;
         max_abs_err <= '0;
      end else begin
         en_d <= en;
         if (!en) en_blk <= 1'b0;
         if (clr) begin
            done        <= 1'b0;
            last_err    <= '0;
            sample_cnt  <= '0;
            err_cnt     <= '0;
            abort_cnt   <= '0;
            abs_err_sum <= '0;
            max_abs_err <= '0;
         end else begin
            done <= upd;
            if (state_q == S_IDLE && rise) cnt_q <= CW'(LAT);
            else if (state_q == S_WAIT && en) cnt_q <= cnt_q - CW'(1);
            if (abort_evt) abort_cnt <= sat_inc(abort_cnt);
            if (upd) begin
               last_err    <= err_q;
               sample_cnt  <= sat_inc(sample_cnt);
               if (err_q != '0) err_cnt <= sat_inc(err_cnt);
               abs_err_sum <= asum_next;
               if (abs_c > max_abs_err) max_abs_err <= abs_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_app_mult_err_monitor.sv
// -----------------------------------------------------------------------------
// tb_app_mult_err_monitor
//
// Two monitors (ACC_W=32 and ACC_W=4) share one directed stimulus stream. A
// request-level model tracks each request from its start edge, derives abort,
// sample and update edges from LAT, and keeps the statistics with plain
// integer arithmetic. Outputs are compared on every falling edge; literal
// expectations at milestones pin the model.
// -----------------------------------------------------------------------------
module tb_app_mult_err_monitor;

   localparam int W1  = 8;
   localparam int W2  = 8;
   localparam int LAT = 3;
   localparam int PW  = W1 + W2;
   localparam int EW  = PW + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   logic clr = 1'b0;
   logic en  = 1'b0;
   logic signed [W1-1:0] a = '0;
   logic signed [W2-1:0] b = '0;
   logic signed [PW-1:0] s = '0;

   logic          done0, done1;
   logic [EW-1:0] le0, le1, mx0, mx1;
   logic [31:0]   smp0, erc0, abt0, asm0;
   logic [3:0]    smp1, erc1, abt1, asm1;

   app_mult_err_monitor #(.WIDTH1(W1), .WIDTH2(W2), .LAT(LAT), .ACC_W(32)) u_mon32 (
      .sys_clk(clk), .sys_rst(rst), .en(en), .A(a), .B(b), .sum(s), .clr(clr),
      .done(done0), .last_err(le0), .sample_cnt(smp0), .err_cnt(erc0),
      .abort_cnt(abt0), .abs_err_sum(asm0), .max_abs_err(mx0));

   app_mult_err_monitor #(.WIDTH1(W1), .WIDTH2(W2), .LAT(LAT), .ACC_W(4)) u_mon4 (
      .sys_clk(clk), .sys_rst(rst), .en(en), .A(a), .B(b), .sum(s), .clr(clr),
      .done(done1), .last_err(le1), .sample_cnt(smp1), .err_cnt(erc1),
      .abort_cnt(abt1), .abs_err_sum(asm1), .max_abs_err(mx1));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- request-level model ----------------
   longint m_max_cnt [2] = '{(longint'(1) << 32) - 1, (longint'(1) << 4) - 1};
   longint m_sample [2];
   longint m_errc   [2];
   longint m_abort  [2];
   longint m_asum   [2];
   longint m_last, m_max, m_err;
   bit     m_done;
   bit     m_prev, m_pend;
   longint m_n = 0, m_t0, m_upd_at = -1, m_a0, m_b0;

   function automatic longint sat_add(input longint v, input longint d, input longint mx);
      return (v + d > mx) ? mx : v + d;
   endfunction

   task automatic model_zero();
      for (int k = 0; k < 2; k++) begin
         m_sample[k] = 0; m_errc[k] = 0; m_abort[k] = 0; m_asum[k] = 0;
      end
      m_last = 0; m_max = 0; m_done = 0; m_pend = 0; m_upd_at = -1;
   endtask

   always @(posedge clk) begin
      bit     busy;
      longint ab;
      m_n++;
      if (rst) begin
         model_zero();
      end else if (clr) begin
         model_zero();
      end else begin
         m_done = 0;
         busy   = m_pend || (m_upd_at == m_n);
         if (m_upd_at == m_n) begin
            ab = (m_err < 0) ? -m_err : m_err;
            m_last = m_err;
            if (ab > m_max) m_max = ab;
            for (int k = 0; k < 2; k++) begin
               m_sample[k] = sat_add(m_sample[k], 1, m_max_cnt[k]);
               if (m_err != 0) m_errc[k] = sat_add(m_errc[k], 1, m_max_cnt[k]);
               m_asum[k] = sat_add(m_asum[k], ab, m_max_cnt[k]);
            end
            m_done   = 1;
            m_upd_at = -1;
         end
         if (m_pend) begin
            if (!en) begin
               for (int k = 0; k < 2; k++) m_abort[k] = sat_add(m_abort[k], 1, m_max_cnt[k]);
               m_pend = 0;
            end else if (m_n == m_t0 + LAT) begin
               m_err    = longint'(s) - m_a0 * m_b0;
               m_pend   = 0;
               m_upd_at = m_n + 1;
            end
         end
         if (!busy && en && !m_prev) begin
            m_pend = 1; m_t0 = m_n;
            m_a0 = longint'(a); m_b0 = longint'(b);
         end
      end
      m_prev = en;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      check("done32",   longint'(done0),        longint'(m_done));
      check("done4",    longint'(done1),        longint'(m_done));
      check("last32",   longint'($signed(le0)), m_last);
      check("last4",    longint'($signed(le1)), m_last);
      check("max32",    longint'(mx0),          m_max);
      check("max4",     longint'(mx1),          m_max);
      check("sample32", longint'(smp0),         m_sample[0]);
      check("sample4",  longint'(smp1),         m_sample[1]);
      check("errc32",   longint'(erc0),         m_errc[0]);
      check("errc4",    longint'(erc1),         m_errc[1]);
      check("abort32",  longint'(abt0),         m_abort[0]);
      check("abort4",   longint'(abt1),         m_abort[1]);
      check("asum32",   longint'(asm0),         m_asum[0]);
      check("asum4",    longint'(asm1),         m_asum[1]);
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input bit e, input bit c = 1'b0, input bit r = 1'b0);
      en = e; clr = c; rst = r;
      @(negedge clk);
   endtask

   // Full request: en high on t0..t0+LAT, low on the UPDATE edge.
   task automatic req(input int av, input int bv, input int sv);
      a = W1'(av); b = W2'(bv); s = PW'(sv);
      repeat (LAT + 1) cyc(1'b1);
      cyc(1'b0);
   endtask

   initial begin
      // Reset with en held high: no request may start until en falls.
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b1);
      cyc(1'b1);
      cyc(1'b0);
      check("lit_rst_sample", longint'(smp0), 0);
      check("lit_rst_abort",  longint'(abt0), 0);
      check("lit_rst_done",   longint'(done0), 0);

      // Exact result
      req(12, 10, 120);
      check("lit_exact_last",   longint'($signed(le0)), 0);
      check("lit_exact_sample", longint'(smp0), 1);
      check("lit_exact_errc",   longint'(erc0), 0);
      check("lit_exact_asum",   longint'(asm0), 0);
      check("model_exact_sample", m_sample[0], 1);

      // Signed errors from a clean slate
      cyc(1'b0, 1'b1);
      check("lit_clr_sample", longint'(smp0), 0);
      req(5, -3, -16);
      check("lit_s1_last", longint'($signed(le0)), -1);
      check("lit_s1_errc", longint'(erc0), 1);
      check("lit_s1_asum", longint'(asm0), 1);
      check("lit_s1_max",  longint'(mx0), 1);
      req(-128, -128, 16380);
      check("lit_s2_last",   longint'($signed(le0)), -4);
      check("lit_s2_asum",   longint'(asm0), 5);
      check("lit_s2_max",    longint'(mx0), 4);
      check("lit_s2_sample", longint'(smp0), 2);
      check("model_s2_last", m_last, -4);

      // Abort: en high for only two edges
      a = 8'sd3; b = 8'sd3; s = 16'sd9;
      cyc(1'b1); cyc(1'b1); cyc(1'b0); cyc(1'b0);
      check("lit_abort_cnt",    longint'(abt0), 1);
      check("lit_abort_sample", longint'(smp0), 2);
      req(3, 3, 9);
      check("lit_after_abort_sample", longint'(smp0), 3);
      check("lit_after_abort_last",   longint'($signed(le0)), 0);

      // clr on the UPDATE edge
      a = 8'sd4; b = 8'sd4; s = 16'sd1;
      repeat (LAT + 1) cyc(1'b1);
      cyc(1'b0, 1'b1);
      cyc(1'b0);
      check("lit_clrupd_sample", longint'(smp0), 0);
      check("lit_clrupd_abort",  longint'(abt0), 0);
      check("lit_clrupd_max",    longint'(mx0), 0);
      check("lit_clrupd_done",   longint'(done0), 0);

      // Saturation: 20 back-to-back requests, |err| = 3 each
      repeat (20) req(2, 3, 9);
      check("lit_sat4_sample",   longint'(smp1), 15);
      check("lit_sat4_errc",     longint'(erc1), 15);
      check("lit_sat4_asum",     longint'(asm1), 15);
      check("lit_sat32_sample",  longint'(smp0), 20);
      check("lit_sat32_asum",    longint'(asm0), 60);
      check("lit_sat_max",       longint'(mx0), 3);
      check("model_sat4_asum",   m_asum[1], 15);

      // Reset mid-WAIT, then a normal request
      a = 8'sd9; b = 8'sd9; s = 16'sd0;
      cyc(1'b1); cyc(1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0);
      check("lit_rstw_sample", longint'(smp0), 0);
      check("lit_rstw_abort",  longint'(abt0), 0);
      check("lit_rstw_max",    longint'(mx0), 0);
      check("lit_rstw_last",   longint'($signed(le0)), 0);
      req(7, -2, -14);
      check("lit_post_rst_sample", longint'(smp0), 1);
      check("lit_post_rst_errc",   longint'(erc0), 0);

      repeat (3) cyc(1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
